data_memory_responder: RTL and testbench

Responder end of the pipeline processor's data-memory port: accepts the MEM-stage address, write data and write enable every cycle and returns read data the same cycle for capture into MEM/WB. Decodes a word-addressed RAM region and a small memory-mapped I/O page. The I/O page holds a GPIO output register, a transmit FIFO drained by an external consumer over a valid/ready handshake, a status register and a free-running cycle counter. Sits at the top level beside the processor, between its MEM port and the board-level I/O.

---
 rtl/data_memory_responder_pkg.sv | 20 ++
 rtl/data_memory_responder_tx_fifo.sv | 72 +++++++
 rtl/data_memory_responder.sv | 131 +++++++++++++
 tb/tb_data_memory_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: I/O page offsets and STATUS bit layout.
// Firmware and the bench decode the I/O page with these same constants.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    IO_GPIO      = 2'd0,
    IO_FIFO_DATA = 2'd1,
    IO_STATUS    = 2'd2,
    IO_CYCLE     = 2'd3
  } io_off_e;

  localparam int STAT_COUNT_W    = 4;
  localparam int STAT_EMPTY      = 4;
  localparam int STAT_FULL       = 5;
  localparam int STAT_OVERFLOW   = 6;
  localparam int STAT_ACCESS_ERR = 7;

  localparam int CYCLE_W = 20;

endpackage

// File: rtl/data_memory_responder_tx_fifo.sv
// Circular transmit FIFO; head word is held in registers so TxData stays stable until popped.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module tx_fifo #(
  parameter int DATA_WIDTH = 20,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
          mem_q[gi] <= data_i;
        end
      end
    end
  endgenerate

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: word RAM plus a 4-word I/O page (GPIO, TX FIFO, STATUS, CYCLE).
// Read data is combinational from the address so the MEM stage can capture it the same cycle.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int                    DATA_WIDTH = 20,
  parameter int                    ADDR_BITS  = 8,
  parameter logic [DATA_WIDTH-1:0] IO_BASE    = 20'h00F00,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  write_enable_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic [DATA_WIDTH-1:0] gpio_out_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  access_error_o
);

  localparam int                    RAM_WORDS = 2 ** ADDR_BITS;
  localparam int                    CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] RAM_TOP   = DATA_WIDTH'(RAM_WORDS);

  logic [DATA_WIDTH-1:0] ram_q [RAM_WORDS];
  logic [DATA_WIDTH-1:0] gpio_q, gpio_d;
  logic [CYCLE_W-1:0]    cycle_q, cycle_d;
  logic                  overflow_q, overflow_d;
  logic                  access_err_q, access_err_d;

  logic                  in_ram, io_hit, unmapped;
  logic [DATA_WIDTH-1:0] io_rel;
  io_off_e               io_off;
  logic                  ram_we, gpio_we, fifo_push, status_we, cycle_we;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] status_word, read_data;

  assign in_ram   = (address_i < RAM_TOP);
  assign io_rel   = address_i - IO_BASE;
  assign io_hit   = (address_i >= IO_BASE) && (io_rel < DATA_WIDTH'(4));
  assign io_off   = io_off_e'(io_rel[1:0]);
  assign unmapped = !in_ram && !io_hit;

  assign ram_we    = write_enable_i && in_ram;
  assign gpio_we   = write_enable_i && io_hit && (io_off == IO_GPIO);
  assign fifo_push = write_enable_i && io_hit && (io_off == IO_FIFO_DATA);
  assign status_we = write_enable_i && io_hit && (io_off == IO_STATUS);
  assign cycle_we  = write_enable_i && io_hit && (io_off == IO_CYCLE);
  assign fifo_pop  = tx_valid_o && tx_ready_i;

  tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (write_data_i),
    .data_o  (tx_data_o),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_valid_o     = !fifo_empty;
  assign gpio_out_o     = gpio_q;
  assign access_error_o = access_err_q;

  // RAM contents survive reset, so this array carries no reset branch.
  always_ff @(posedge clk_i) begin
    if (ram_we) ram_q[address_i[ADDR_BITS-1:0]] <= write_data_i;
  end

  // Set events take priority over software clears in the same cycle.
  always_comb begin
    gpio_d       = gpio_we ? write_data_i : gpio_q;
    cycle_d      = cycle_we ? write_data_i[CYCLE_W-1:0] : cycle_q + CYCLE_W'(1);
    overflow_d   = overflow_q;
    access_err_d = access_err_q;
    if (status_we && write_data_i[STAT_OVERFLOW])   overflow_d   = 1'b0;
    if (status_we && write_data_i[STAT_ACCESS_ERR]) access_err_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop)        overflow_d   = 1'b1;
    if (write_enable_i && unmapped)                 access_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_q       <= '0;
      cycle_q      <= '0;
      overflow_q   <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      gpio_q       <= gpio_d;
      cycle_q      <= cycle_d;
      overflow_q   <= overflow_d;
      access_err_q <= access_err_d;
    end
  end

  always_comb begin
    status_word                  = '0;
    status_word[STAT_COUNT_W-1:0] = STAT_COUNT_W'(fifo_count);
    status_word[STAT_EMPTY]      = fifo_empty;
    status_word[STAT_FULL]       = fifo_full;
    status_word[STAT_OVERFLOW]   = overflow_q;
    status_word[STAT_ACCESS_ERR] = access_err_q;
  end

  always_comb begin
    read_data = '0;
    if (in_ram) begin
      read_data = ram_q[address_i[ADDR_BITS-1:0]];
    end else if (io_hit) begin
      case (io_off)
        IO_GPIO:      read_data = gpio_q;
        IO_FIFO_DATA: read_data = '0;
        IO_STATUS:    read_data = status_word;
        IO_CYCLE:     read_data = DATA_WIDTH'(cycle_q);
        default:      read_data = '0;
      endcase
    end
  end

  assign data_out_o = rst_ni ? read_data : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: RAM, decode errors, GPIO, TX FIFO, CYCLE and async reset.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam logic [19:0] IO   = 20'h00F00;
  localparam logic [19:0] A_GP = IO + 20'(IO_GPIO);
  localparam logic [19:0] A_FD = IO + 20'(IO_FIFO_DATA);
  localparam logic [19:0] A_ST = IO + 20'(IO_STATUS);
  localparam logic [19:0] A_CY = IO + 20'(IO_CYCLE);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] addr, wdata;
  logic        we, tx_ready;
  logic [19:0] data_out, gpio_out, tx_data;
  logic        tx_valid, access_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_memory_responder #(
    .DATA_WIDTH (20),
    .ADDR_BITS  (8),
    .IO_BASE    (IO),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .address_i      (addr),
    .write_data_i   (wdata),
    .write_enable_i (we),
    .data_out_o     (data_out),
    .gpio_out_o     (gpio_out),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_ready_i     (tx_ready),
    .access_error_o (access_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [19:0] a, input logic [19:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    $display("wr addr=%h data=%h", a, d);
  endtask

  task automatic rd(input string tag, input logic [19:0] a, input logic [19:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    check(tag, 32'(data_out), 32'(exp));
    $display("rd addr=%h data=%h", a, data_out);
  endtask

  logic [19:0] drain_exp [4];

  initial begin
    rst_n = 1'b0; addr = 20'd5; wdata = '0; we = 1'b0; tx_ready = 1'b0;
    #1;
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_valid", 32'(tx_valid), 32'h0);
    check("rst_txdata", 32'(tx_data), 32'h0);
    check("rst_aerr", 32'(access_error), 32'h0);
    check("rst_dout", 32'(data_out), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    rd("cycle_start", A_CY, 20'h00000);
    tick();
    rd("cycle_first", A_CY, 20'h00001);

    // RAM and address decode
    wr(20'd5, 20'h12345);
    rd("ram5", 20'd5, 20'h12345);
    rd("unmapped_rd", 20'h00500, 20'h0);
    check("aerr_after_rd", 32'(access_error), 32'h0);
    wr(20'h00500, 20'h00777);
    check("aerr_after_wr", 32'(access_error), 32'h1);
    rd("status_aerr", A_ST, 20'h00090);
    wr(A_ST, 20'h00080);
    check("aerr_cleared", 32'(access_error), 32'h0);
    rd("status_idle", A_ST, 20'h00010);

    // GPIO with read-during-write
    wr(A_GP, 20'hABCDE);
    check("gpio_load", 32'(gpio_out), 32'hABCDE);
    rd("gpio_rd", A_GP, 20'hABCDE);
    addr = A_GP; wdata = 20'h11111; we = 1'b1;
    #1;
    check("gpio_rdw_old", 32'(data_out), 32'hABCDE);
    tick();
    we = 1'b0;
    check("gpio_new", 32'(gpio_out), 32'h11111);

    // FIFO overflow: A5 dropped
    for (int i = 0; i < 5; i++) wr(A_FD, 20'hA0001 + 20'(i));
    check("ovf_valid", 32'(tx_valid), 32'h1);
    check("ovf_head", 32'(tx_data), 32'hA0001);
    rd("status_full_ovf", A_ST, 20'h00064);
    rd("fifo_data_rd", A_FD, 20'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drainA_valid", 32'(tx_valid), 32'h1);
      check("drainA_data", 32'(tx_data), 32'hA0001 + 32'(i));
      tick();
    end
    check("drainA_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    rd("status_ovf_sticky", A_ST, 20'h00050);
    wr(A_ST, 20'h00040);
    rd("status_ovf_clr", A_ST, 20'h00010);

    // Push into a full FIFO while popping
    for (int i = 0; i < 4; i++) wr(A_FD, 20'hC0000 + 20'(i));
    rd("status_full", A_ST, 20'h00024);
    tx_ready = 1'b1; addr = A_FD; wdata = 20'hB0000; we = 1'b1;
    #1;
    check("pushpop_head", 32'(tx_data), 32'hC0000);
    tick();
    we = 1'b0; tx_ready = 1'b0;
    rd("status_pushpop", A_ST, 20'h00024);
    check("pushpop_newhead", 32'(tx_data), 32'hC0001);
    drain_exp[0] = 20'hC0001; drain_exp[1] = 20'hC0002;
    drain_exp[2] = 20'hC0003; drain_exp[3] = 20'hB0000;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drainB_data", 32'(tx_data), 32'(drain_exp[i]));
      tick();
    end
    tx_ready = 1'b0;
    check("drainB_empty", 32'(tx_valid), 32'h0);

    // Asynchronous reset mid-drain with 3 words held
    wr(20'h00600, 20'h0);
    for (int i = 0; i < 4; i++) wr(A_FD, 20'hD0001 + 20'(i));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    rd("status_pre_rst", A_ST, 20'h00083);
    check("pre_rst_head", 32'(tx_data), 32'hD0002);
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(tx_valid), 32'h0);
    check("async_gpio", 32'(gpio_out), 32'h0);
    check("async_txdata", 32'(tx_data), 32'h0);
    check("async_aerr", 32'(access_error), 32'h0);
    check("async_dout", 32'(data_out), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    rd("status_post_rst", A_ST, 20'h00010);
    rd("ram5_post_rst", 20'd5, 20'h12345);

    // CYCLE load and wrap
    wr(A_CY, 20'hFFFFE);
    rd("cycle_loaded", A_CY, 20'hFFFFE);
    tick();
    rd("cycle_max", A_CY, 20'hFFFFF);
    tick();
    rd("cycle_wrap", A_CY, 20'h00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
